// File: rtl/reg_pkg.sv
// Shared types for the parallel register unload path.
// Optional parity framing is selected with REG_SERIAL_UNLOAD_PARITY_EN.
package reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } unload_state_t;

  localparam int REG_W = 8;

endpackage

// File: rtl/bit_counter.sv
// Bit position counter with synchronous clear and enable.
// The terminal count flags position N-1; advancing past it wraps to 0.
module bit_counter
  import reg_pkg::*;
#(
  parameter int N = REG_W
) (
  input  logic clk,
  input  logic clear_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] TERM = CW'(N - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/reg_serial_unload.sv
// Serialises a captured N-bit register word LSB first, with zero-gap back-to-back frames.
// Defining REG_SERIAL_UNLOAD_PARITY_EN appends an even-parity bit to each frame.
module reg_serial_unload
  import reg_pkg::*;
#(
  parameter int N = REG_W
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic [N-1:0] in,
  input  logic         load,
  output logic         ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         last,
  output logic         busy
);

  unload_state_t state;
  logic [N-1:0]  shreg;
  logic          tc;
  logic          accept;

`ifdef REG_SERIAL_UNLOAD_PARITY_EN
  logic par_bit;
`endif

  // Handshake: a word transfers on a posedge where load & ready; ready is
  // combinational so a new word can land on the same edge the last bit leaves.
  assign ready  = clear_n & ((state == IDLE) | (last & shift_en));
  assign accept = load & ready;
  assign busy   = (state != IDLE);

  bit_counter #(.N(N)) u_bit_counter (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (accept),
    .en      (shift_en & (state == SHIFT)),
    .tc      (tc)
  );

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    case (state)
      SHIFT: begin
        sout       = shreg[0];
        sout_valid = 1'b1;
`ifndef REG_SERIAL_UNLOAD_PARITY_EN
        last       = tc;
`endif
      end
`ifdef REG_SERIAL_UNLOAD_PARITY_EN
      PAR: begin
        sout       = par_bit;
        sout_valid = 1'b1;
        last       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= in;
    end else if (shift_en) begin
      case (state)
        SHIFT: begin
          shreg <= shreg >> 1;
          if (tc) begin
`ifdef REG_SERIAL_UNLOAD_PARITY_EN
            state <= PAR;
`else
            state <= IDLE;
`endif
          end
        end
        PAR:     state <= IDLE;
        default: ;
      endcase
    end
  end

`ifdef REG_SERIAL_UNLOAD_PARITY_EN
  // Parity is taken from the captured word, since in may change after acceptance.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ^in;
    end
  end
`endif

endmodule

// File: tb/tb_reg_serial_unload.sv
// Directed bench for reg_serial_unload: frame order, back-to-back, stall, ignored load, abort.
// Parity expectations follow REG_SERIAL_UNLOAD_PARITY_EN when it is defined.
module tb_reg_serial_unload;

  localparam int N = 8;
`ifdef REG_SERIAL_UNLOAD_PARITY_EN
  localparam int FRAME = N + 1;
  localparam bit LAST_ON_DATA = 1'b0;
`else
  localparam int FRAME = N;
  localparam bit LAST_ON_DATA = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         clear_n;
  logic [N-1:0] in_w;
  logic         load;
  logic         ready;
  logic         shift_en;
  logic         sout;
  logic         sout_valid;
  logic         last;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int bits_seen = 0;
  logic [1:0] exp_q[$];  // {last, bit}

  always #5 clk = ~clk;

  reg_serial_unload #(.N(N)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .in         (in_w),
    .load       (load),
    .ready      (ready),
    .shift_en   (shift_en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_bits(input logic [N-1:0] w, input int nbits, input bit full);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back({full && LAST_ON_DATA && (i == N - 1), w[i]});
    end
`ifdef REG_SERIAL_UNLOAD_PARITY_EN
    if (full) exp_q.push_back({1'b1, ^w});
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, sout_valid, 0);
    check({tag, "_sout"}, sout, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input logic [N-1:0] w, input string tag);
    cycle();
    in_w = w;
    load = 1'b1;
    expect_bits(w, N, 1'b1);
    cycle();
    load = 1'b0;
    in_w = '0;
    cycle(FRAME);
    @(negedge clk);
    check_idle(tag);
  endtask

  // Scoreboard: every bit the consumer takes must match the head of exp_q.
  always @(negedge clk) begin
    logic [1:0] e;
    if (sout_valid && shift_en) begin
      check("bit_avail", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sout", sout, e[0]);
        check("last", last, e[1]);
        bits_seen++;
      end
    end
  end

  initial begin
    int b0;
    logic [N-1:0] sw;

    clear_n  = 1'b0;
    load     = 1'b0;
    shift_en = 1'b1;
    in_w     = '0;
    cycle(2);
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_valid", sout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", last, 0);
    check("rst_sout", sout, 0);
    cycle();
    clear_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    run_frame(8'hA5, "a5_end");

    // Back-to-back: second word presented during the last bit.
    cycle();
    in_w = 8'h0F;
    load = 1'b1;
    expect_bits(8'h0F, N, 1'b1);
    expect_bits(8'hF0, N, 1'b1);
    b0 = bits_seen;
    cycle();
    load = 1'b0;
    cycle(FRAME - 1);
    in_w = 8'hF0;
    load = 1'b1;
    @(negedge clk);
    check("b2b_ready", ready, 1);
    cycle();
    load = 1'b0;
    in_w = '0;
    @(negedge clk);
    check("b2b_nogap", sout_valid, 1);
    cycle(FRAME);
    @(negedge clk);
    check_idle("b2b_end");
    check("b2b_bits", bits_seen - b0, 2 * FRAME);

    // Stall for 3 cycles while bit 2 is showing.
    sw = 8'h81;
    cycle();
    in_w = sw;
    load = 1'b1;
    expect_bits(sw, N, 1'b1);
    cycle();
    load = 1'b0;
    cycle(2);
    shift_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_sout", sout, sw[2]);
      check("stall_last", last, 0);
      check("stall_valid", sout_valid, 1);
      check("stall_ready", ready, 0);
      cycle();
    end
    shift_en = 1'b1;
    cycle(FRAME - 2);
    @(negedge clk);
    check_idle("stall_end");

    // load held mid-frame must be ignored until the last-bit cycle.
    cycle();
    in_w = 8'hC3;
    load = 1'b1;
    expect_bits(8'hC3, N, 1'b1);
    cycle();
    in_w = 8'hFF;
    for (int k = 0; k < FRAME - 1; k++) begin
      @(negedge clk);
      check("mid_ready", ready, 0);
      check("mid_busy", busy, 1);
      cycle();
    end
    load = 1'b0;
    @(negedge clk);
    check("mid_last_ready", ready, 1);
    check("mid_last", last, 1);
    cycle();
    @(negedge clk);
    check_idle("mid_end");

    // Reset during bit 4 aborts the frame.
    cycle();
    in_w = 8'h3C;
    load = 1'b1;
    expect_bits(8'h3C, 5, 1'b0);
    cycle();
    load = 1'b0;
    cycle(4);
    clear_n = 1'b0;
    cycle();
    @(negedge clk);
    check("abort_ready", ready, 0);
    check("abort_valid", sout_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_last", last, 0);
    check("abort_sout", sout, 0);
    cycle();
    clear_n = 1'b1;
    @(negedge clk);
    check_idle("abort_rel");

    run_frame(8'h01, "w01_end");
    run_frame(8'h07, "w07_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
